// File: rtl/foc_deadlock_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : foc_deadlock_watchdog
//  Purpose  : Deadlock detector for an HLS dataflow region. A block condition
//             (any unmasked stream channel blocked while at least one
//             sub-instance is busy) must persist for THRESHOLD consecutive
//             cycles before a sticky deadlock flag is raised. The first
//             blocking channel and the deadlock duration are recorded.
//  Ports    :
//    clock_i             system clock
//    reset_i             synchronous, active-high reset
//    enable_i            monitoring enable, 0 forces IDLE
//    clear_i             one-cycle pulse, clears sticky deadlock state
//    axis_block_sigs_i   per-channel stream-blocked indication
//    axis_mask_i         per-channel ignore mask (1 = ignore)
//    inst_idle_sigs_i    per-instance idle indication
//    block_o             registered qualified-block (1-cycle latency)
//    deadlock_o          sticky deadlock flag
//    deadlock_chan_o     lowest unmasked blocked channel at streak start
//    deadlock_cycles_o   cycles spent in DEADLOCK, saturating
//    state_o             FSM state: 0 IDLE, 1 SUSPECT, 2 DEADLOCK
//  Revision : 1.0 - initial release
// ============================================================================
module foc_deadlock_watchdog #(
  parameter int NUM_AXIS  = 10,
  parameter int NUM_INST  = 5,
  parameter int THRESHOLD = 1024,
  parameter int IDX_W     = 6,
  parameter int DUR_W     = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [NUM_AXIS-1:0] axis_block_sigs_i,
  input  logic [NUM_AXIS-1:0] axis_mask_i,
  input  logic [NUM_INST-1:0] inst_idle_sigs_i,
  output logic                block_o,
  output logic                deadlock_o,
  output logic [IDX_W-1:0]    deadlock_chan_o,
  output logic [DUR_W-1:0]    deadlock_cycles_o,
  output logic [1:0]          state_o
);

  // Streak counter only ever reaches THRESHOLD, so it never wraps.
  localparam int CNT_W = $clog2(THRESHOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   chan_q, chan_d;
  logic [DUR_W-1:0]   cycles_q, cycles_d;
  logic               block_q;

  logic [NUM_AXIS-1:0] unmasked_blk;
  logic                qblk;
  logic [IDX_W-1:0]    first_idx;
  logic [CNT_W-1:0]    cnt_inc;

  // A fully idle region cannot be deadlocked, whatever the streams report.
  assign unmasked_blk = axis_block_sigs_i & ~axis_mask_i;
  assign qblk         = enable_i & (|unmasked_blk) & ~(&inst_idle_sigs_i);
  assign cnt_inc      = cnt_q + CNT_W'(1);

  // Priority encoder: scanning from the top down leaves the lowest set index.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (unmasked_blk[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chan_d   = chan_q;
    cycles_d = cycles_q;
    if (clear_i || !enable_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      chan_d   = '0;
      cycles_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qblk) begin
            chan_d   = first_idx;
            cnt_d    = CNT_W'(1);
            cycles_d = '0;
            state_d  = (THRESHOLD == 1) ? ST_DEADLOCK : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (!qblk) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            chan_d  = '0;
          end else begin
            // Channel index stays frozen for the whole streak.
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(THRESHOLD)) begin
              state_d = ST_DEADLOCK;
            end
          end
        end
        ST_DEADLOCK: begin
          // Sticky: only clear, enable drop or reset leave this state.
          if (cycles_q != {DUR_W{1'b1}}) begin
            cycles_d = cycles_q + DUR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          chan_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      chan_q   <= '0;
      cycles_q <= '0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      cycles_q <= cycles_d;
      block_q  <= qblk;
    end
  end

  assign block_o           = block_q;
  assign deadlock_o        = (state_q == ST_DEADLOCK);
  assign deadlock_chan_o   = chan_q;
  assign deadlock_cycles_o = cycles_q;
  assign state_o           = state_q;

endmodule
`default_nettype wire

// File: doc/foc_deadlock_watchdog.md
Name: foc_deadlock_watchdog

Overview:
- Parametrised deadlock detector for HLS dataflow regions in the FOC pipeline.
- Generalises the fixed per-instance monitors to NUM_AXIS stream channels and NUM_INST instances, with per-channel masking.
- Adds a persistence filter: a block condition must hold for THRESHOLD consecutive cycles before a sticky deadlock flag is raised.
- On a deadlock it records the first blocking channel index and counts how long the deadlock has lasted. Sits beside the dataflow region; its outputs feed a status register and debug ILA.

Parameters:
- NUM_AXIS, 10, number of AXI-Stream blocking signals monitored (1..64)
- NUM_INST, 5, number of sub-instance idle signals (1..32)
- THRESHOLD, 1024, consecutive qualified-block cycles required to declare deadlock (1..65535)
- IDX_W, 6, width of channel index output; must satisfy 2^IDX_W >= NUM_AXIS
- DUR_W, 16, width of deadlock duration counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  monitoring enable; 0 forces IDLE
- clear  in  1  one-cycle pulse; clears sticky deadlock state
- axis_block_sigs  in  NUM_AXIS  per-channel stream-blocked indication
- axis_mask  in  NUM_AXIS  1 = ignore channel
- inst_idle_sigs  in  NUM_INST  per-instance idle indication
- block  out  1  registered qualified-block, 1-cycle latency
- deadlock  out  1  sticky deadlock flag
- deadlock_chan  out  IDX_W  lowest-index unmasked blocked channel at start of the streak
- deadlock_cycles  out  DUR_W  cycles spent in DEADLOCK, saturating
- state  out  2  FSM state: 0 IDLE, 1 SUSPECT, 2 DEADLOCK

Behaviour:
- Clock and reset: one clock `clock`. `reset` is synchronous and active-high.
- Qualified block: qblk = enable & |(axis_block_sigs & ~axis_mask) & ~(&inst_idle_sigs). A fully idle region is never deadlocked.
- `block` register: block <= qblk on every edge. Reset value 0.
- Reset values: all outputs 0; state IDLE; internal streak counter 0.
- Priority order: reset > clear > enable=0 > normal FSM.
- clear or enable=0:
  - state -> IDLE; streak counter and deadlock_cycles -> 0; deadlock -> 0; deadlock_chan -> 0.
  - The cycle in which clear is asserted is never counted as part of a streak.
- IDLE:
  - If qblk: capture the lowest set index of (axis_block_sigs & ~axis_mask) into deadlock_chan, and set cnt = 1.
  - Then, if THRESHOLD == 1, go to DEADLOCK with deadlock = 1; otherwise go to SUSPECT.
  - If not qblk: stay in IDLE.
- SUSPECT:
  - If not qblk: go to IDLE, cnt = 0, deadlock_chan = 0.
  - Else cnt = cnt + 1. When cnt + 1 == THRESHOLD: go to DEADLOCK, deadlock = 1.
  - deadlock_chan is not updated during a streak, even if the blocking channel changes.
- DEADLOCK:
  - Sticky regardless of qblk; exits only via clear, enable=0 or reset.
  - deadlock_cycles increments by 1 each cycle from the first cycle in DEADLOCK, starting at 0 on entry, and saturates at 2^DUR_W - 1.
  - deadlock_chan is held.
- Timing: deadlock rises on the edge that samples the THRESHOLD-th consecutive qblk = 1. A qblk = 0 gap of one cycle restarts the streak.
- Mask: axis_mask changes take effect combinationally in the same cycle.
- Width of cnt: ceil(log2(THRESHOLD + 1)) bits; it never wraps.

Test Plan:
- THRESHOLD = 4. Reset, then axis_block_sigs = 0x020 held, idle = 0 -> block = 1 after 1 cycle; state 1 for 3 edges; deadlock = 1 after edge 4; deadlock_chan = 5; deadlock_cycles counts 0, 1, 2…
- THRESHOLD = 4. blk = 0x020 for 3 cycles, then 0 for 1 cycle, then 0x020 for 3 cycles -> deadlock stays 0 and state returns to 0 at the gap.
- Masking and idle qualification:
  - blk = 0x300 with axis_mask = 0x100 -> deadlock_chan = 9.
  - blk = 0x100 with mask = 0x100 -> block stays 0.
  - All inst_idle_sigs = 0x1F with blk = 0x3FF -> block stays 0.
- Deadlocked with qblk dropped to 0 -> deadlock remains 1. Pulse clear -> next cycle deadlock = 0, state = 0, deadlock_cycles = 0. A fresh streak needs 4 further cycles.
- DUR_W = 4, THRESHOLD = 1. Hold the block for 30 cycles -> deadlock after 1 edge; deadlock_cycles saturates at 15.
- Mid-SUSPECT checks:
  - Assert reset during SUSPECT (cnt = 2) -> all outputs 0 next edge.
  - Drop enable in SUSPECT -> state IDLE and block = 0.
  - Assert clear on the same cycle as the THRESHOLD-th qblk -> no deadlock.
